// File: rtl/tile_pkg.sv
// Shared constants, palette and write-FSM encoding for the tile map renderer.
package tile_pkg;

  localparam int unsigned TILE_SIZE = 32;
  localparam int unsigned MAP_W     = 20;
  localparam int unsigned MAP_H     = 15;
  localparam int unsigned MAP_DEPTH = MAP_W * MAP_H;

  // Raster totals; used to pull o_Wr_Ready low one pixel before the frame wraps.
  localparam int unsigned H_TOTAL   = 800;
  localparam int unsigned V_TOTAL   = 525;

  // {R,G,B} per tile ID; entry 0 is never shown.
  localparam logic [7:0][2:0] PALETTE = {3'b111, 3'b101, 3'b011, 3'b110,
                                         3'b001, 3'b010, 3'b100, 3'b000};

  typedef enum logic [1:0] {
    StClear,
    StDisplay,
    StVblank
  } wr_state_e;

endpackage

// File: rtl/tile_pattern_rom.sv
// 8 tiles x 32 rows x 32 bits pattern ROM with a registered (1-cycle) read.
module tile_pattern_rom
  import tile_pkg::*;
(
  input  logic       clk_i,
  input  logic [2:0] tile_i,
  input  logic [4:0] py_i,
  input  logic [4:0] px_i,
  output logic       bit_o
);

  // Every tile has a lit top/left edge; the interior is a 4-pixel checker whose
  // phase flips with the tile ID LSB so neighbouring IDs look different.
  function automatic logic [31:0] pattern_row(input logic [2:0] tile, input logic [4:0] py);
    logic [31:0] row;
    row = '0;
    for (int px = 0; px < 32; px++) begin
      row[px] = (px == 0) || (py == 5'd0) || (1'(px >> 2) ^ py[2] ^ tile[0]);
    end
    return row;
  endfunction

  logic [31:0] row_word;

  assign row_word = pattern_row(tile_i, py_i);

  always_ff @(posedge clk_i) begin
    bit_o <= row_word[px_i];
  end

endmodule

// File: rtl/tile_map_renderer.sv
// Tile-map renderer: 3-stage pixel pipeline over a 300-entry tile map that is
// cleared after reset and only writable during vertical blanking.
module tile_map_renderer #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned TILE_SIZE = 32,
  parameter int unsigned MAP_W     = 20,
  parameter int unsigned MAP_H     = 15
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_HSync,
  input  logic       i_VSync,
  input  logic [9:0] i_Col_Count,
  input  logic [9:0] i_Row_Count,
  input  logic       i_Wr_Valid,
  input  logic [8:0] i_Wr_Addr,
  input  logic [2:0] i_Wr_Tile,
  output logic       o_Wr_Ready,
  output logic       o_Wr_Err,
  output logic       o_Frame_Start,
  output logic       o_VGA_HSync,
  output logic       o_VGA_VSync,
  output logic       o_VGA_Red_2,
  output logic       o_VGA_Grn_2,
  output logic       o_VGA_Blu_2
);

  import tile_pkg::*;

  localparam int unsigned TileShift = $clog2(TILE_SIZE);
  localparam int unsigned MapDepth  = MAP_W * MAP_H;
  localparam logic [9:0]  HVis      = 10'(H_VISIBLE);
  localparam logic [9:0]  VVis      = 10'(V_VISIBLE);
  localparam logic [9:0]  HLast     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  VLast     = 10'(V_TOTAL - 1);
  localparam logic [8:0]  MapLast   = 9'(MapDepth - 1);

  logic [2:0] map_q [MapDepth];

  // Stage 1: coordinate decode.
  logic [9:0] tile_col, tile_row;
  logic [8:0] pix_addr;
  logic       pix_vis;

  assign tile_col = i_Col_Count >> TileShift;
  assign tile_row = i_Row_Count >> TileShift;
  assign pix_addr = 9'(tile_row * 10'(MAP_W) + tile_col);
  assign pix_vis  = (i_Col_Count < HVis) && (i_Row_Count < VVis);

  logic [8:0] s1_addr_q;
  logic [4:0] s1_px_q, s1_py_q;
  logic       s1_vis_q;
  logic [2:0] s2_tile_q;
  logic       s2_vis_q;
  logic [2:0] rgb_q, rgb_d;
  logic [2:0] hs_q, vs_q;
  logic       fs_q;
  logic [2:0] rd_tile;
  logic       pat_bit;

  // Off-map addresses only occur for invisible pixels; read them as tile 0.
  assign rd_tile = (s1_addr_q <= MapLast) ? map_q[s1_addr_q] : 3'd0;
  assign rgb_d   = (s2_vis_q && (s2_tile_q != 3'd0) && pat_bit) ? PALETTE[s2_tile_q] : 3'b000;

  tile_pattern_rom u_rom (
    .clk_i  (i_Clk),
    .tile_i (rd_tile),
    .py_i   (s1_py_q),
    .px_i   (s1_px_q),
    .bit_o  (pat_bit)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      s1_addr_q <= '0;
      s1_px_q   <= '0;
      s1_py_q   <= '0;
      s1_vis_q  <= 1'b0;
      s2_tile_q <= '0;
      s2_vis_q  <= 1'b0;
      rgb_q     <= '0;
      hs_q      <= '1;
      vs_q      <= '1;
      fs_q      <= 1'b0;
    end else begin
      s1_addr_q <= pix_addr;
      s1_px_q   <= i_Col_Count[4:0];
      s1_py_q   <= i_Row_Count[4:0];
      s1_vis_q  <= pix_vis;
      s2_tile_q <= rd_tile;
      s2_vis_q  <= s1_vis_q;
      rgb_q     <= rgb_d;
      hs_q      <= {hs_q[1:0], i_HSync};
      vs_q      <= {vs_q[1:0], i_VSync};
      fs_q      <= (i_Col_Count == 10'd0) && (i_Row_Count == 10'd0);
    end
  end

  // Write-side FSM.
  wr_state_e  state_q, state_d;
  logic [8:0] clr_cnt_q, clr_cnt_d;
  logic       wr_ready_q, wr_ready_d;
  logic       wr_err_q, wr_err_d;
  logic       in_vblank, last_px, accept;
  logic       map_we;
  logic [8:0] map_waddr;
  logic [2:0] map_wdata;

  assign in_vblank = i_Row_Count >= VVis;
  assign last_px   = (i_Row_Count == VLast) && (i_Col_Count == HLast);
  assign accept    = i_Wr_Valid && wr_ready_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StClear: begin
        if (clr_cnt_q == MapLast) begin
          clr_cnt_d = '0;
          state_d   = in_vblank ? StVblank : StDisplay;
        end else begin
          clr_cnt_d = clr_cnt_q + 9'd1;
        end
      end
      StDisplay: if (in_vblank) state_d = StVblank;
      StVblank:  if (!in_vblank) state_d = StDisplay;
      default:   state_d = StClear;
    endcase
    // Drop ready on the final pixel of the frame so no write can land on row 0.
    wr_ready_d = (state_d == StVblank) && !last_px;
    wr_err_d   = accept && (i_Wr_Addr > MapLast);
  end

  always_comb begin
    map_we    = 1'b0;
    map_waddr = i_Wr_Addr;
    map_wdata = i_Wr_Tile;
    if (state_q == StClear) begin
      map_we    = 1'b1;
      map_waddr = clr_cnt_q;
      map_wdata = 3'd0;
    end else if (accept && (i_Wr_Addr <= MapLast)) begin
      map_we = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= StClear;
      clr_cnt_q  <= '0;
      wr_ready_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wr_ready_q <= wr_ready_d;
      wr_err_q   <= wr_err_d;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (map_we) map_q[map_waddr] <= map_wdata;
  end

  assign o_Wr_Ready    = wr_ready_q;
  assign o_Wr_Err      = wr_err_q;
  assign o_Frame_Start = fs_q;
  assign o_VGA_HSync   = hs_q[2];
  assign o_VGA_VSync   = vs_q[2];
  assign o_VGA_Red_2   = rgb_q[2];
  assign o_VGA_Grn_2   = rgb_q[1];
  assign o_VGA_Blu_2   = rgb_q[0];

endmodule

// File: doc/tile_map_renderer.md
TILE_MAP_RENDERER -- requirements
Module: tile_map_renderer

Interface
REQ-001 SHALL have parameters: H_VISIBLE 640, active columns; V_VISIBLE 480, active rows; TILE_SIZE 32, tile edge in pixels (power of two); MAP_W 20, tiles per row; MAP_H 15, tile rows.
REQ-002 SHALL have ports (name  direction  width  meaning):
- i_Clk  in  1  pixel clock; the only clock.
- i_Rst_L  in  1  reset, asynchronous, active-low.
- i_HSync  in  1  horizontal sync from the timing generator.
- i_VSync  in  1  vertical sync from the timing generator.
- i_Col_Count  in  10  current pixel column, 0..H_TOTAL-1.
- i_Row_Count  in  10  current pixel row, 0..V_TOTAL-1.
- i_Wr_Valid  in  1  tile-write request.
- i_Wr_Addr  in  9  linear tile index, row*MAP_W+col.
- i_Wr_Tile  in  3  tile ID to store.
- o_Wr_Ready  out  1  write accepted this cycle when high with i_Wr_Valid.
- o_Wr_Err  out  1  one-cycle pulse: accepted write had i_Wr_Addr >= 300.
- o_Frame_Start  out  1  one-cycle pulse at pixel (0,0) input.
- o_VGA_HSync  out  1  i_HSync delayed to match pixel latency.
- o_VGA_VSync  out  1  i_VSync delayed to match pixel latency.
- o_VGA_Red_2  out  1  pixel red.
- o_VGA_Grn_2  out  1  pixel green.
- o_VGA_Blu_2  out  1  pixel blue.

Function
REQ-003 SHALL hold a 300-entry x 3-bit tile map, addressed row*20+col.
REQ-004 SHALL compute per pixel tile_col = col[9:5], tile_row = row[8:5], px = col[4:0], py = row[4:0].
REQ-005 SHALL produce the pixel in a 3-stage pipeline:
- stage 1: register map address, px, py, and the visible flag (col<640 && row<480).
- stage 2: read the tile ID from the map.
- stage 3: read pattern bit ROM[tile_id][py][px] and register RGB.
REQ-006 SHALL give the sync outputs exactly 3 cycles of latency, identical to the RGB outputs.
REQ-007 SHALL output RGB as follows:
- visible flag low -> RGB = 000.
- tile ID 0 -> RGB = 000 regardless of pattern.
- pattern bit 1 -> RGB = PALETTE[tile_id].
- pattern bit 0 -> RGB = 000.
REQ-008 SHALL implement a write FSM with three states:
- CLEAR: entered on reset; writes 0 to map addresses 0..299, one per cycle; then goes to DISPLAY.
- DISPLAY: active while i_Row_Count < 480.
- VBLANK: active while i_Row_Count >= 480.
REQ-009 SHALL drive o_Wr_Ready high only in the VBLANK state, as a registered output, so the map never changes during active video.
REQ-010 SHALL treat a write as accepted in a cycle where i_Wr_Valid && o_Wr_Ready; addr < 300 updates the map on that edge.
REQ-011 SHALL drop an accepted write with addr >= 300, leave the map unchanged, and pulse o_Wr_Err the next cycle.
REQ-012 SHALL keep the CLEAR sweep unaffected by writes; o_Wr_Ready is 0 throughout CLEAR.
REQ-013 SHALL apply a write and a display read that hit the same address in the same cycle (possible only in VBLANK) with read-old-data behaviour; this is invisible because RGB is 000 in VBLANK.
REQ-014 SHALL pulse o_Frame_Start for one cycle, registered, when inputs col==0 && row==0.
REQ-015 SHALL, on a VBLANK->DISPLAY transition with i_Wr_Valid held high, deassert o_Wr_Ready on the first DISPLAY-state cycle and accept nothing further.

Reset
REQ-016 SHALL set, on i_Rst_L low (asynchronous): all RGB 000, o_VGA_HSync and o_VGA_VSync 1, o_Wr_Ready 0, o_Wr_Err 0, o_Frame_Start 0, pipeline valid flags 0, FSM state CLEAR, clear counter 0.
REQ-017 SHALL abandon any sweep or write in progress when reset is asserted mid-operation; the CLEAR sweep restarts from address 0 on release.

Structure
REQ-018 SHALL place TILE_SIZE, MAP_W, MAP_H, MAP_DEPTH=300, the 8-entry 3-bit PALETTE, and the FSM state encoding in shared package tile_pkg.
REQ-019 SHALL place the pattern ROM (8 tiles x 32 rows x 32 bits, synchronous read, 1-cycle latency) in sub-module tile_pattern_rom.

Verification
REQ-020 Release reset -> o_Wr_Ready 0 for exactly 300 cycles; all 300 map entries read 0; then o_Wr_Ready follows the vblank condition.
REQ-021 In VBLANK, write addr 21 tile 3 -> in the next frame, pixels col 32..63 / row 32..63 show PALETTE[3] wherever the ROM bit is 1, appearing 3 cycles after the matching input coordinates.
REQ-022 Write addr 300 -> o_Wr_Err pulses one cycle; map contents unchanged.
REQ-023 Hold i_Wr_Valid high across row 479->480 and row 524->0 -> no acceptance while row < 480; acceptance resumes at row 480.
REQ-024 Any coordinate with col >= 640 or row >= 480 -> RGB 000; o_VGA_HSync and o_VGA_VSync equal i_HSync and i_VSync delayed by exactly 3 cycles.
REQ-025 Assert i_Rst_L low at clear address 150 -> all outputs take reset values immediately; the sweep restarts at address 0 and runs the full 300 cycles.
